// File: rtl/data_mem_responder_if.sv
// Data-port bus between the core's load/store unit and the memory responder:
// a valid/ready request channel and a valid/ready response channel.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] data_from_mem;
    logic        resp_err;

    modport master (
        output req_valid,
        output WE,
        output address_to_mem,
        output data_to_mem,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  data_from_mem,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  WE,
        input  address_to_mem,
        input  data_to_mem,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output data_from_mem,
        output resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-port memory responder: word RAM behind valid/ready request and response
// channels, fixed response latency, misaligned/out-of-range accesses flagged.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [31:0]   mem_r [DEPTH_WORDS];
    state_t        state_r;
    state_t        state_n_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_n_s;
    logic          accept_s;
    logic [31:0]   off_s;
    logic          misaligned_s;
    logic          out_of_range_s;
    logic          err_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   load_val_s;
    logic [31:0]   pend_data_r;
    logic          pend_err_r;
    logic          req_ready_r;
    logic          resp_valid_r;
    logic [31:0]   data_out_r;
    logic          err_out_r;

    // Address decode; the subtraction wraps so addresses below the base fall out of range
    always_comb begin
        off_s          = bus.address_to_mem - BASE_ADDR;
        misaligned_s   = (bus.address_to_mem[1:0] != 2'b00);
        out_of_range_s = (off_s >= SPAN_BYTES);
        err_s          = misaligned_s | out_of_range_s;
        idx_s          = off_s[AW+1:2];
        if (!bus.WE && !err_s) begin
            load_val_s = mem_r[idx_s];
        end else begin
            load_val_s = 32'h0000_0000;
        end
    end

    // Next-state and accept logic
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_n_s = ST_RESP;
                    end else begin
                        state_n_s = ST_WAIT;
                        cnt_n_s   = LAT_M1;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_n_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_n_s = ST_RESP;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RESP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = 4'd0;
            end
        endcase
    end

    // State, pending response and registered bus outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            pend_data_r  <= 32'h0000_0000;
            pend_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            data_out_r   <= 32'h0000_0000;
            err_out_r    <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
            req_ready_r  <= (state_n_s == ST_IDLE);
            resp_valid_r <= (state_n_s == ST_RESP);
            if (accept_s) begin
                pend_data_r <= load_val_s;
                pend_err_r  <= err_s;
            end
            // Response fields are only driven while the response is presented
            if (state_n_s == ST_RESP) begin
                if (accept_s) begin
                    data_out_r <= load_val_s;
                    err_out_r  <= err_s;
                end else begin
                    data_out_r <= pend_data_r;
                    err_out_r  <= pend_err_r;
                end
            end else begin
                data_out_r <= 32'h0000_0000;
                err_out_r  <= 1'b0;
            end
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (reset && accept_s && bus.WE && !err_s) begin
            mem_r[idx_s] <= bus.data_to_mem;
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.data_from_mem = data_out_r;
    assign bus.resp_err      = err_out_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances cover LATENCY 2/1/5/4
// and a non-zero base address; inputs are shared, req_valid/reset per instance.
module tb_data_mem_responder;
    logic        clk;
    logic [3:0]  reset_s;
    logic [3:0]  req_valid_s;
    logic        we_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic        resp_ready_s;
    logic        rdy_s   [4];
    logic        rv_s    [4];
    logic [31:0] rd_s    [4];
    logic        re_s    [4];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_mem_responder_if bus ();
        assign bus.req_valid      = req_valid_s[g];
        assign bus.WE             = we_s;
        assign bus.address_to_mem = addr_s;
        assign bus.data_to_mem    = wdata_s;
        assign bus.resp_ready     = resp_ready_s;
        assign rdy_s[g]           = bus.req_ready;
        assign rv_s[g]            = bus.resp_valid;
        assign rd_s[g]            = bus.data_from_mem;
        assign re_s[g]            = bus.resp_err;

        data_mem_responder #(
            .DEPTH_WORDS (256),
            .BASE_ADDR   ((g == 3) ? 32'h0000_1000 : 32'h0000_0000),
            .LATENCY     ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 4)
        ) u_dut (
            .clk   (clk),
            .reset (reset_s[g]),
            .bus   (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance s; lat counts cycles after the accept edge
    task automatic do_req(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic busy_ok);
        @(negedge clk);
        req_valid_s[s] = 1'b1;
        we_s           = we;
        addr_s         = a;
        wdata_s        = d;
        resp_ready_s   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_s[s] = 1'b0;
        we_s           = ~we;
        addr_s         = ~a;
        wdata_s        = ~d;
        lat            = 1;
        busy_ok        = 1'b1;
        while (!rv_s[s] && lat < 40) begin
            if (rdy_s[s] !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (rdy_s[s] !== 1'b0) busy_ok = 1'b0;
        rdata = rd_s[s];
        err   = re_s[s];
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        busy;
    logic        flag;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total        = 0;
        bad          = 0;
        reset_s      = 4'b0000;
        req_valid_s  = 4'b0000;
        we_s         = 1'b0;
        addr_s       = 32'h0000_0000;
        wdata_s      = 32'h0000_0000;
        resp_ready_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_req_ready", 32'(rdy_s[i]), 32'd1);
            chk("rst_resp_valid", 32'(rv_s[i]), 32'd0);
            chk("rst_data", rd_s[i], 32'h0000_0000);
            chk("rst_err", 32'(re_s[i]), 32'd0);
        end
        reset_s = 4'b1111;

        do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rdata, err, lat, busy);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_err", 32'(err), 32'd0);
        chk("st_data", rdata, 32'h0000_0000);
        chk("st_busy", 32'(busy), 32'd1);
        chk("st_after_ready", 32'(rdy_s[0]), 32'd1);
        chk("st_after_valid", 32'(rv_s[0]), 32'd0);
        chk("st_after_data", rd_s[0], 32'h0000_0000);

        do_req(0, 1'b0, 32'h0000_0010, 32'h0000_0000, rdata, err, lat, busy);
        chk("ld_lat", 32'(lat), 32'd2);
        chk("ld_err", 32'(err), 32'd0);
        chk("ld_data", rdata, 32'hDEAD_BEEF);

        do_req(0, 1'b1, 32'h0000_0013, 32'h1234_5678, rdata, err, lat, busy);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_data", rdata, 32'h0000_0000);
        do_req(0, 1'b0, 32'h0000_0010, 32'h0000_0000, rdata, err, lat, busy);
        chk("mis_nowrite", rdata, 32'hDEAD_BEEF);
        chk("mis_nowrite_err", 32'(err), 32'd0);

        do_req(1, 1'b1, 32'h0000_0040, 32'hA5A5_0001, rdata, err, lat, busy);
        chk("l1_st_lat", 32'(lat), 32'd1);
        do_req(1, 1'b0, 32'h0000_0040, 32'h0000_0000, rdata, err, lat, busy);
        chk("l1_ld_lat", 32'(lat), 32'd1);
        chk("l1_ld_data", rdata, 32'hA5A5_0001);
        chk("l1_busy", 32'(busy), 32'd1);

        do_req(2, 1'b1, 32'h0000_0040, 32'h5A5A_0002, rdata, err, lat, busy);
        chk("l5_st_lat", 32'(lat), 32'd5);
        do_req(2, 1'b0, 32'h0000_0040, 32'h0000_0000, rdata, err, lat, busy);
        chk("l5_ld_lat", 32'(lat), 32'd5);
        chk("l5_ld_data", rdata, 32'h5A5A_0002);
        chk("l5_busy", 32'(busy), 32'd1);

        do_req(3, 1'b1, 32'h0000_13FC, 32'h0BAD_F00D, rdata, err, lat, busy);
        chk("oor_top_st_err", 32'(err), 32'd0);
        chk("l4_lat", 32'(lat), 32'd4);
        do_req(3, 1'b0, 32'h0000_1400, 32'h0000_0000, rdata, err, lat, busy);
        chk("oor_hi_err", 32'(err), 32'd1);
        chk("oor_hi_data", rdata, 32'h0000_0000);
        do_req(3, 1'b0, 32'h0000_0FFC, 32'h0000_0000, rdata, err, lat, busy);
        chk("oor_lo_err", 32'(err), 32'd1);
        chk("oor_lo_data", rdata, 32'h0000_0000);
        do_req(3, 1'b0, 32'h0000_13FC, 32'h0000_0000, rdata, err, lat, busy);
        chk("oor_top_ld_err", 32'(err), 32'd0);
        chk("oor_top_ld_data", rdata, 32'h0BAD_F00D);

        // Backpressure: load held in RESP while a second request waits on req_valid
        @(negedge clk);
        req_valid_s[0] = 1'b1;
        we_s           = 1'b0;
        addr_s         = 32'h0000_0010;
        resp_ready_s   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        we_s    = 1'b1;
        addr_s  = 32'h0000_0020;
        wdata_s = 32'h0000_2020;
        lat     = 0;
        while (!rv_s[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_valid", 32'(rv_s[0]), 32'd1);
        chk("bp_data", rd_s[0], 32'hDEAD_BEEF);
        flag = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rv_s[0] !== 1'b1 || rd_s[0] !== 32'hDEAD_BEEF || re_s[0] !== 1'b0 || rdy_s[0] !== 1'b0)
                flag = 1'b0;
        end
        chk("bp_stable", 32'(flag), 32'd1);
        resp_ready_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 32'(rdy_s[0]), 32'd1);
        chk("bp_release_valid", 32'(rv_s[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_accepted", 32'(rdy_s[0]), 32'd0);
        req_valid_s[0] = 1'b0;
        lat = 1;
        while (!rv_s[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_next_lat", 32'(lat), 32'd2);
        chk("bp_next_data", rd_s[0], 32'h0000_0000);
        @(posedge clk);
        do_req(0, 1'b0, 32'h0000_0020, 32'h0000_0000, rdata, err, lat, busy);
        chk("bp_next_readback", rdata, 32'h0000_2020);

        // Reset one cycle after a load accept on the LATENCY=4 instance
        do_req(3, 1'b1, 32'h0000_1020, 32'hCAFE_F00D, rdata, err, lat, busy);
        chk("rw_st_err", 32'(err), 32'd0);
        @(negedge clk);
        req_valid_s[3] = 1'b1;
        we_s           = 1'b0;
        addr_s         = 32'h0000_1020;
        resp_ready_s   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_s[3] = 1'b0;
        reset_s[3]     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rw_valid", 32'(rv_s[3]), 32'd0);
        chk("rw_ready", 32'(rdy_s[3]), 32'd1);
        reset_s[3] = 1'b1;
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rv_s[3] !== 1'b0) flag = 1'b1;
        end
        chk("rw_no_resp", 32'(flag), 32'd0);
        do_req(3, 1'b0, 32'h0000_1020, 32'h0000_0000, rdata, err, lat, busy);
        chk("rw_readback", rdata, 32'hCAFE_F00D);
        chk("rw_readback_lat", 32'(lat), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data port; it serves the load/store requests the core issues.
- Word-organised synchronous RAM with a valid/ready request channel, a valid/ready response channel and a programmable response latency.
- One outstanding request at a time.
- Flags misaligned and out-of-range accesses instead of silently aliasing them.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 2: cycles from request acceptance to resp_valid assertion; range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- WE  in  1  1 = store, 0 = load; qualified by req_valid
- address_to_mem  in  32  byte address
- data_to_mem  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester consumes the response
- data_from_mem  out  32  load data; 0 for stores and for errors
- resp_err  out  1  access was misaligned or out of range; valid with resp_valid

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; req_ready=1, resp_valid=0, data_from_mem=0, resp_err=0, latency counter=0.
  - RAM contents are not cleared and are retained across reset.
- Accept: a request is accepted on a posedge where req_valid && req_ready. WE, address and data are captured at that edge.
- Decode:
  - off = address_to_mem - BASE_ADDR (32-bit wrap).
  - misaligned = address_to_mem[1:0] != 0.
  - out_of_range = off >= DEPTH_WORDS*4, unsigned compare.
  - err = misaligned | out_of_range.
  - Word index = off[log2(DEPTH_WORDS)+1:2].
- Store: if !err, RAM[index] is written at the accept edge. If err, there is no write.
- Load: if !err, RAM[index] is read at the accept edge into the response register; if err, 0 is loaded.
- State machine:
  - IDLE: req_ready=1. On accept: if LATENCY==1, go to RESP; else go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at counter==1 the next state is RESP.
  - RESP: req_ready=0, resp_valid=1. data_from_mem and resp_err are held stable until resp_valid && resp_ready at a posedge, then return to IDLE.
- Latency: accept at edge k puts resp_valid high in the cycle after edge k+LATENCY-1. With LATENCY=1, resp_valid is high in the cycle directly after the accept edge.
- Throughput: req_ready is combinational on state only and does not depend on req_valid or resp_ready. The earliest next accept is the edge after the response handshake edge, so the maximum rate is one request per LATENCY+1 cycles.
- Backpressure: resp_ready low in RESP holds all response outputs indefinitely; no new request is accepted.
- Response field rules:
  - data_from_mem is 0 for stores.
  - resp_err is meaningful only while resp_valid is high and must be 0 otherwise.
  - When resp_valid is low, data_from_mem is 0.
- Inputs outside a handshake are ignored. Requester-side changes after acceptance have no effect on the response.
- Reset mid-operation:
  - In WAIT or RESP, the pending response is discarded and the state goes to IDLE.
  - A store accepted before the reset edge remains written.
  - A request presented on the reset edge is not accepted.
- Address wrap: off is computed modulo 2^32, so addresses below BASE_ADDR are out of range.

Test Plan:
- Store/load, LATENCY=2, BASE=0: store 32'hDEADBEEF to 0x10. Response is valid 2 cycles after accept with resp_err=0, data_from_mem=0. Load 0x10 returns 32'hDEADBEEF with resp_err=0.
- Latency sweep LATENCY=1 and 5: load accepted at edge k has resp_valid high exactly in cycle k+1 and k+5 respectively. req_ready is 0 from accept until the handshake edge.
- Misaligned store to 0x13 of 32'h12345678 gives resp_err=1. A subsequent load of 0x10 returns its prior value, proving no write occurred.
- Out of range (DEPTH_WORDS=256, BASE=32'h1000):
  - Load from 0x1400 gives resp_err=1, data_from_mem=0.
  - Load from 0x0FFC gives resp_err=1.
  - Load from 0x13FC gives resp_err=0.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP. resp_valid and data stay stable, and req_ready stays 0 while req_valid=1. Raise resp_ready: handshake occurs, and the next request is accepted on the following edge.
- Reset mid-WAIT (LATENCY=4): assert reset=0 one cycle after a load accept. Next cycle: resp_valid=0, req_ready=1, and no response ever appears. A store issued before the reset is read back intact.
